alpha_stack: RTL and testbench

Window-based LIFO buffer for forward state metrics in the FPTD decoder. It sits directly downstream of the razor-protected alpha recursion stage. During the forward pass it captures the seven normalised alpha metrics (`alpha_0` is implicitly zero) once per trellis step. During the backward pass it returns them in reverse order to the LLR/beta stage. An optional counter records how many stored steps were flagged with a razor timing error.

---
 rtl/fptd_pkg.sv | 13 +
 rtl/alpha_stack_mem.sv | 23 ++
 rtl/alpha_stack.sv | 127 ++++++++++++
 tb/tb_alpha_stack.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fptd_pkg.sv
// rtl/fptd_pkg.sv - shared FPTD decoder types and constants
package fptd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } alpha_stack_state_t;

  localparam int ALPHA_NUM = 7;
  localparam int ERRCNT_W  = 16;

endpackage

// File: rtl/alpha_stack_mem.sv
// rtl/alpha_stack_mem.sv - DEPTH x W storage, synchronous write, registered read, no reset
module alpha_stack_mem #(
  parameter int DEPTH = 32,
  parameter int W     = 42,
  parameter int AW    = 5
) (
  input  logic          Clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/alpha_stack.sv
// rtl/alpha_stack.sv - window LIFO for forward alpha metrics (IDLE/FILL/DRAIN)
// Optional razor error counter enabled by ALPHA_STACK_ERRCNT_EN.
module alpha_stack
  import fptd_pkg::*;
#(
  parameter int M     = 6,
  parameter int DEPTH = 32
) (
  input  logic                        Clock,
  input  logic                        nReset,
  input  logic                        wr_en,
  input  logic                        wr_last,
  input  logic [ALPHA_NUM:1][M-1:0]   alpha_in,
  input  logic                        Error_current_Alpha,
  input  logic                        rd_en,
  output logic [ALPHA_NUM:1][M-1:0]   alpha_rd,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        busy_drain,
  output logic                        overflow,
  output logic [ERRCNT_W-1:0]         err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = ALPHA_NUM * M;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  alpha_stack_state_t state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  rd_data;
  logic          wr_ok, pop, ovf_set, rd_seen;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_seen  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      rd_valid <= pop;
      rd_seen  <= rd_seen | pop;
      overflow <= overflow | ovf_set;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wr_ok     = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    wr_addr   = '0;
    case (state)
      IDLE: begin
        if (wr_en) begin
          wr_ok     = 1'b1;
          count_nxt = CW'(1);
          state_nxt = wr_last ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (wr_en) begin
          wr_ok     = 1'b1;
          wr_addr   = AW'(count);
          count_nxt = count + CW'(1);
          if (wr_last || count_nxt == DEPTH_C) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        pop = rd_en && (count != '0);
        if (pop) count_nxt = count - CW'(1);
        // A write coinciding with the final pop (or the empty tail cycle) opens the next window at address 0.
        if (wr_en && ((count == '0) || (pop && count == CW'(1)))) begin
          wr_ok     = 1'b1;
          count_nxt = CW'(1);
          state_nxt = wr_last ? DRAIN : FILL;
        end else begin
          ovf_set = wr_en;
          if (count == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  alpha_stack_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_mem (
    .Clock   (Clock),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (alpha_in),
    .rd_en   (pop),
    .rd_addr (AW'(count - CW'(1))),
    .rd_data (rd_data)
  );

  // Storage has no reset, so the output reads zero until the first pop after reset.
  assign alpha_rd   = rd_seen ? rd_data : '0;
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign busy_drain = (state == DRAIN);

`ifdef ALPHA_STACK_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) err_q <= '0;
    else if (wr_ok && Error_current_Alpha && (err_q != '1)) err_q <= err_q + ERRCNT_W'(1);
  end

  assign err_count = err_q;
`else
  logic unused_err;
  assign unused_err = Error_current_Alpha;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_alpha_stack.sv
// tb/tb_alpha_stack.sv - randomized self-checking bench for alpha_stack against a queue model
module tb_alpha_stack;

  localparam int M = 6;
  localparam int D = 4;
  localparam int W = 7 * M;

  logic              Clock = 1'b0;
  logic              nReset, wr_en, wr_last, Error_current_Alpha, rd_en;
  logic [7:1][M-1:0] alpha_in, alpha_rd;
  logic              rd_valid, full, empty, busy_drain, overflow;
  logic [15:0]       err_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q[$];
  int           ph;
  bit           m_ovf;
  int           m_err;
  logic [W-1:0] m_rd;
  bit           m_valid;

  alpha_stack #(.M(M), .DEPTH(D)) dut (
    .Clock               (Clock),
    .nReset              (nReset),
    .wr_en               (wr_en),
    .wr_last             (wr_last),
    .alpha_in            (alpha_in),
    .Error_current_Alpha (Error_current_Alpha),
    .rd_en               (rd_en),
    .alpha_rd            (alpha_rd),
    .rd_valid            (rd_valid),
    .full                (full),
    .empty               (empty),
    .busy_drain          (busy_drain),
    .overflow            (overflow),
    .err_count           (err_count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] vec(input logic [M-1:0] a1);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    r[M-1:0] = a1;
    return r[W-1:0];
  endfunction

  task automatic check_all(input string where);
    int exp_err;
`ifdef ALPHA_STACK_ERRCNT_EN
    exp_err = m_err;
`else
    exp_err = 0;
`endif
    check({where, ".rd_valid"},   64'(rd_valid),   64'(m_valid));
    check({where, ".alpha_rd"},   64'(alpha_rd),   64'(m_rd));
    check({where, ".full"},       64'(full),       64'(q.size() == D));
    check({where, ".empty"},      64'(empty),      64'(q.size() == 0));
    check({where, ".busy_drain"}, 64'(busy_drain), 64'(ph == 2));
    check({where, ".overflow"},   64'(overflow),   64'(m_ovf));
    check({where, ".err_count"},  64'(err_count),  64'(exp_err));
  endtask

  task automatic model_reset();
    q.delete();
    ph = 0; m_ovf = 0; m_err = 0; m_rd = '0; m_valid = 0;
  endtask

  // One clock of stimulus; the model applies the window rules to a plain LIFO queue.
  task automatic tick(input string where, input bit wr, input bit last,
                      input logic [W-1:0] d, input bit err, input bit rd);
    int  sz;
    bit  acc, pop;
    wr_en = wr; wr_last = last; alpha_in = d; Error_current_Alpha = err; rd_en = rd;
    sz  = q.size();
    pop = (ph == 2) && rd && (sz > 0);
    acc = wr && ((ph == 0) || (ph == 1) || ((ph == 2) && ((sz == 0) || (pop && sz == 1))));
    m_valid = pop;
    if (pop) m_rd = q.pop_back();
    if (wr && ph == 2 && !acc) m_ovf = 1;
    if (acc) begin
      q.push_back(d);
      if (err && m_err < 65535) m_err++;
      ph = (last || q.size() == D) ? 2 : 1;
    end else if (ph == 2 && sz == 0) begin
      ph = 0;
    end
    @(posedge Clock);
    #1;
    check_all(where);
  endtask

  task automatic idle(input string where);
    tick(where, 0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    wr_en = 0; rd_en = 0; wr_last = 0; Error_current_Alpha = 0;
    nReset = 1'b0;
    #2;
    model_reset();
    check_all("async_reset");
    @(posedge Clock);
    #1;
    nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b0; wr_en = 0; wr_last = 0; rd_en = 0; Error_current_Alpha = 0; alpha_in = '0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    check_all("reset");
    nReset = 1'b1;

    tick("full_w1", 1, 0, vec(6'd1), 0, 0);
    tick("full_w2", 1, 0, vec(6'd2), 0, 1);
    tick("full_w3", 1, 0, vec(6'd3), 0, 0);
    tick("full_w4", 1, 0, vec(6'h3C), 0, 0);
    for (int i = 0; i < 4; i++) tick("full_pop", 0, 0, '0, 0, 1);
    idle("full_idle");

    tick("early_w1", 1, 0, vec(6'h21), 0, 0);
    tick("early_w2", 1, 1, vec(6'h1F), 0, 0);
    for (int i = 0; i < 3; i++) tick("early_pop", 0, 0, '0, 0, 1);
    idle("early_idle");

    tick("ovf_w1", 1, 0, vec(6'h05), 0, 0);
    tick("ovf_w2", 1, 1, vec(6'h2A), 0, 0);
    tick("ovf_wr_drain", 1, 0, vec(6'h11), 0, 1);
    tick("ovf_pop", 0, 0, '0, 0, 1);
    idle("ovf_tail");
    idle("ovf_idle");

    do_reset();
    for (int i = 0; i < 3; i++) tick("rst_w", 1, 0, vec(6'(i + 7)), 0, 0);
    do_reset();
    tick("rst_one", 1, 1, vec(6'h33), 0, 0);
    tick("rst_pop", 0, 0, '0, 0, 1);
    idle("rst_tail");

    tick("err_w1", 1, 0, vec(6'h01), 1, 0);
    tick("err_w2", 1, 0, vec(6'h02), 0, 0);
    tick("err_w3", 1, 0, vec(6'h03), 1, 0);
    tick("err_w4", 1, 0, vec(6'h04), 1, 0);
    for (int i = 0; i < 4; i++) tick("err_pop", 0, 0, '0, 0, 1);

    do_reset();
    tick("b2b_w1", 1, 0, vec(6'h0A), 0, 0);
    tick("b2b_w2", 1, 1, vec(6'h0B), 0, 0);
    tick("b2b_pop", 0, 0, '0, 0, 1);
    tick("b2b_pop_wr", 1, 1, vec(6'h0C), 0, 1);
    tick("b2b_new_pop", 0, 0, '0, 0, 1);
    idle("b2b_tail");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      tick("rand", $urandom_range(0, 99) < 50, $urandom_range(0, 3) == 0,
           vec(6'($urandom())), 1'($urandom()), $urandom_range(0, 99) < 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
